seg7_scan: RTL and testbench

Seven-segment display scanner that consumes the divided clock produced by the team's clock divider (ClkDiv) and time-multiplexes NUM_DIGITS hex digits onto a shared segment bus. It runs on the fast system clock and treats the divided clock purely as data. It synchronises that input, detects its rising edges, and advances one digit per edge. A one-cycle inter-digit blanking interval suppresses ghosting. It sits directly downstream of the divider and drives the board anode/cathode pins.

---
 rtl/seg7_scan_if.sv | 24 ++
 rtl/seg7_scan.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Signal bundle between the scanner and its surroundings: the divided tick and
// the digit data come in, the anode/cathode pin drives and frame marker go out.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    tick_clk;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_start;

    modport master (
        output tick_clk, digits, dp_in, blank,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  tick_clk, digits, dp_in, blank,
        output an, seg, dp, frame_start
    );
endinterface

// File: rtl/seg7_scan.sv
// Seven-segment scanner: steps one digit per rising edge of the (synchronised)
// divided tick, with a one-clk dark gap between digits to suppress ghosting.
module seg7_scan #(
    parameter int NUM_DIGITS = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    seg7_scan_if.slave bus
);
    // state | meaning
    // BLANK | one-clk inter-digit gap: anodes, segments and dp all dark
    // SHOW  | selected digit driven until the next tick_rise

    localparam int                    IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};
    localparam logic                  DP_OFF   = ACTIVE_LOW;

    generate
        if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_num_digits
            $error("seg7_scan: NUM_DIGITS must lie in 2..16");
        end
    endgenerate

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            4'hF:    s = 7'b1110001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tick_meta_q, tick_meta_d;
    logic                  tick_sync_q, tick_sync_d;
    logic                  tick_prev_q, tick_prev_d;
    logic                  tick_rise_q, tick_rise_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_q, frame_d;

    logic [3:0]            sel_nib;
    logic                  sel_dp;
    logic                  sel_blank;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [IDX_W-1:0]      idx_next;

    always_comb begin
        sel_nib    = bus.digits[{idx_q, 2'b00} +: 4];
        sel_dp     = bus.dp_in[idx_q];
        sel_blank  = bus.blank[idx_q];
        sel_onehot = NUM_DIGITS'(1) << idx_q;
        idx_next   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // The tick is treated as data: two-flop synchroniser, then a registered edge pulse.
    always_comb begin
        tick_meta_d = bus.tick_clk;
        tick_sync_d = tick_meta_q;
        tick_prev_d = tick_sync_q;
        tick_rise_d = tick_sync_q & ~tick_prev_q;
    end

    // Pin registers are loaded at state entry, so they already hold pin polarity.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        frame_d = 1'b0;

        case (state_q)
            ST_BLANK: begin
                state_d = ST_SHOW;
                frame_d = (idx_q == '0);
                if (sel_blank) begin
                    an_d  = AN_OFF;
                    seg_d = SEG_OFF;
                    dp_d  = DP_OFF;
                end else begin
                    an_d  = sel_onehot ^ AN_OFF;
                    seg_d = hex_decode(sel_nib) ^ SEG_OFF;
                    dp_d  = sel_dp ^ DP_OFF;
                end
            end
            ST_SHOW: begin
                if (tick_rise_q) begin
                    state_d = ST_BLANK;
                    idx_d   = idx_next;
                    an_d    = AN_OFF;
                    seg_d   = SEG_OFF;
                    dp_d    = DP_OFF;
                end
            end
            default: begin
                state_d = ST_BLANK;
                an_d    = AN_OFF;
                seg_d   = SEG_OFF;
                dp_d    = DP_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_BLANK;
            idx_q       <= IDX_LAST;
            tick_meta_q <= 1'b0;
            tick_sync_q <= 1'b0;
            tick_prev_q <= 1'b0;
            tick_rise_q <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tick_meta_q <= tick_meta_d;
            tick_sync_q <= tick_sync_d;
            tick_prev_q <= tick_prev_d;
            tick_rise_q <= tick_rise_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frame_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: one active-low and one active-high instance see the same
// stimulus; each is compared every cycle against a slot-level display model.
module tb_seg7_scan;
    localparam int N = 8;
    localparam logic [6:0] HEX [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic          clk;
    logic          reset;
    logic          tick_clk;
    logic [4*N-1:0] digits;
    logic [N-1:0]  dp_in;
    logic [N-1:0]  blank;

    int            n_cmp = 0;
    int            n_err = 0;
    int            exp_idx;
    int            fs_seen;
    logic [16:0]   shown_l, shown_h;
    logic [16:0]   obs_l, obs_h;

    seg7_scan_if #(.NUM_DIGITS(N)) bus_l ();
    seg7_scan_if #(.NUM_DIGITS(N)) bus_h ();

    assign bus_l.tick_clk = tick_clk;
    assign bus_l.digits   = digits;
    assign bus_l.dp_in    = dp_in;
    assign bus_l.blank    = blank;
    assign bus_h.tick_clk = tick_clk;
    assign bus_h.digits   = digits;
    assign bus_h.dp_in    = dp_in;
    assign bus_h.blank    = blank;

    assign obs_l = {bus_l.an, bus_l.seg, bus_l.dp, bus_l.frame_start};
    assign obs_h = {bus_h.an, bus_h.seg, bus_h.dp, bus_h.frame_start};

    seg7_scan #(.NUM_DIGITS(N), .ACTIVE_LOW(1'b1)) u_dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l)
    );

    seg7_scan #(.NUM_DIGITS(N), .ACTIVE_LOW(1'b0)) u_dut_h (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pins {an, seg, dp, frame_start} while slot i is shown.
    function automatic logic [16:0] slot_pins(input bit al, input int i, input logic [4*N-1:0] dg,
                                             input logic [N-1:0] dpv, input logic [N-1:0] bl, input bit fs);
        logic [N-1:0] an_log;
        logic [6:0]   s;
        logic         d;
        if (bl[i]) begin
            an_log = '0;
            s      = '0;
            d      = 1'b0;
        end else begin
            an_log = N'(1 << i);
            s      = HEX[dg[4*i +: 4]];
            d      = dpv[i];
        end
        return {an_log ^ {N{al}}, s ^ {7{al}}, d ^ al, fs};
    endfunction

    function automatic logic [16:0] dark_pins(input bit al);
        return {{N{al}}, {7{al}}, al, 1'b0};
    endfunction

    task automatic run_tick(input int hi, input int lo, input bit scramble);
        int          nxt;
        logic [16:0] new_l, new_h, e_l, e_h;
        nxt   = (exp_idx + 1) % N;
        new_l = slot_pins(1'b1, nxt, digits, dp_in, blank, 1'b0);
        new_h = slot_pins(1'b0, nxt, digits, dp_in, blank, 1'b0);
        @(negedge clk);
        tick_clk = 1'b1;
        for (int k = 0; k < hi + lo; k++) begin
            if (k == hi) tick_clk = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (k < 3) begin
                e_l = shown_l;
                e_h = shown_h;
            end else if (k == 3) begin
                e_l = dark_pins(1'b1);
                e_h = dark_pins(1'b0);
            end else begin
                e_l = new_l;
                e_h = new_h;
                if (k == 4 && nxt == 0) begin
                    e_l[0] = 1'b1;
                    e_h[0] = 1'b1;
                end
            end
            if (bus_l.frame_start === 1'b1) fs_seen++;
            n_cmp++;
            if (obs_l !== e_l) begin
                n_err++;
                $display("FAIL scan_al1 slot=%0d k=%0d got=%h want=%h", nxt, k, obs_l, e_l);
            end
            n_cmp++;
            if (obs_h !== e_h) begin
                n_err++;
                $display("FAIL scan_al0 slot=%0d k=%0d got=%h want=%h", nxt, k, obs_h, e_h);
            end
            if (scramble && k == 4) begin
                digits = $urandom;
                dp_in  = N'($urandom);
                blank  = N'($urandom & $urandom);
            end
        end
        exp_idx = nxt;
        shown_l = new_l;
        shown_h = new_h;
    endtask

    task automatic release_reset;
        @(negedge clk);
        reset   = 1'b0;
        exp_idx = N - 1;
        shown_l = slot_pins(1'b1, N - 1, digits, dp_in, blank, 1'b0);
        shown_h = slot_pins(1'b0, N - 1, digits, dp_in, blank, 1'b0);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs_l !== shown_l) begin
            n_err++;
            $display("FAIL first_show_al1 got=%h want=%h", obs_l, shown_l);
        end
        n_cmp++;
        if (obs_h !== shown_h) begin
            n_err++;
            $display("FAIL first_show_al0 got=%h want=%h", obs_h, shown_h);
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        tick_clk = 1'b0;
        digits   = $urandom;
        dp_in    = N'($urandom);
        blank    = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({bus_l.an, bus_l.seg, bus_l.dp, bus_l.frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL reset_al1 k=%0d got=%h want=%h", k, obs_l, {8'hFF, 7'h7F, 1'b1, 1'b0});
            end
            n_cmp++;
            if (obs_h !== 17'h0) begin
                n_err++;
                $display("FAIL reset_al0 k=%0d got=%h want=0", k, obs_h);
            end
            tick_clk = ~tick_clk;
        end
        tick_clk = 1'b0;
        release_reset();
    endtask

    task automatic test_scan_order;
        digits  = 32'h76543210;
        dp_in   = '0;
        blank   = '0;
        fs_seen = 0;
        for (int t = 0; t < 16; t++) begin
            run_tick(10, 10, 1'b0);
            if (t == 0) begin
                n_cmp++;
                if (bus_l.an !== 8'hFE || bus_l.seg !== 7'b1000000) begin
                    n_err++;
                    $display("FAIL scan_digit0 an=%h seg=%b want FE/1000000", bus_l.an, bus_l.seg);
                end
            end
            if (t == 7) begin
                n_cmp++;
                if (bus_l.an !== 8'h7F || bus_l.seg !== 7'b1111000) begin
                    n_err++;
                    $display("FAIL scan_digit7 an=%h seg=%b want 7F/1111000", bus_l.an, bus_l.seg);
                end
            end
        end
        n_cmp++;
        if (fs_seen != 2) begin
            n_err++;
            $display("FAIL frame_count got=%0d want=2", fs_seen);
        end
    endtask

    task automatic test_latency;
        int          t_blank, t_new, nxt;
        logic [N-1:0] an_new;
        logic [16:0] new_l;
        blank = '0;
        run_tick(10, 10, 1'b0);
        nxt     = (exp_idx + 1) % N;
        an_new  = ~N'(1 << nxt);
        new_l   = slot_pins(1'b1, nxt, digits, dp_in, blank, 1'b0);
        t_blank = -1;
        t_new   = -1;
        @(negedge clk);
        tick_clk = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 10) tick_clk = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (t_blank < 0 && bus_l.an === 8'hFF) t_blank = k;
            if (t_blank >= 0 && t_new < 0 && bus_l.an === an_new) t_new = k;
        end
        n_cmp++;
        if (t_blank != 3) begin
            n_err++;
            $display("FAIL latency_blank got=%0d want=3", t_blank);
        end
        n_cmp++;
        if (t_new != 4) begin
            n_err++;
            $display("FAIL latency_digit got=%0d want=4", t_new);
        end
        n_cmp++;
        if (obs_l !== new_l) begin
            n_err++;
            $display("FAIL latency_pins got=%h want=%h", obs_l, new_l);
        end
        exp_idx = nxt;
        shown_l = new_l;
        shown_h = slot_pins(1'b0, nxt, digits, dp_in, blank, 1'b0);
    endtask

    task automatic test_blank_dp;
        digits = $urandom;
        blank  = 8'h04;
        dp_in  = 8'h02;
        for (int t = 0; t < N; t++) begin
            run_tick(10, 10, 1'b0);
            if (exp_idx == 2) begin
                n_cmp++;
                if (bus_l.an !== 8'hFF || bus_l.seg !== 7'h7F) begin
                    n_err++;
                    $display("FAIL blank_slot2 an=%h seg=%h want FF/7F", bus_l.an, bus_l.seg);
                end
            end
            n_cmp++;
            if (bus_l.dp !== ((exp_idx == 1) ? 1'b0 : 1'b1)) begin
                n_err++;
                $display("FAIL dp_slot%0d got=%b want=%b", exp_idx, bus_l.dp, (exp_idx == 1) ? 1'b0 : 1'b1);
            end
        end
    endtask

    task automatic test_hex_decode;
        blank = '0;
        dp_in = '0;
        for (int v = 0; v < 16; v++) begin
            digits = ($urandom & 32'hFFFF_FFF0) | 32'(v);
            do begin
                run_tick(10, 10, 1'b0);
            end while (exp_idx != 0);
            n_cmp++;
            if (bus_h.seg !== HEX[v]) begin
                n_err++;
                $display("FAIL hex_al0 v=%h got=%b want=%b", v, bus_h.seg, HEX[v]);
            end
            n_cmp++;
            if (bus_l.seg !== ~HEX[v]) begin
                n_err++;
                $display("FAIL hex_al1 v=%h got=%b want=%b", v, bus_l.seg, ~HEX[v]);
            end
            if (v == 10) begin
                n_cmp++;
                if (bus_h.seg !== 7'b1110111) begin
                    n_err++;
                    $display("FAIL hex_A got=%b want=1110111", bus_h.seg);
                end
            end
            if (v == 15) begin
                n_cmp++;
                if (bus_h.seg !== 7'b1110001) begin
                    n_err++;
                    $display("FAIL hex_F got=%b want=1110001", bus_h.seg);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 30; t++) begin
            digits = $urandom;
            dp_in  = N'($urandom);
            blank  = N'($urandom & $urandom);
            run_tick(int'($urandom_range(12, 3)), int'($urandom_range(12, 3)), 1'b1);
        end
    endtask

    task automatic test_reset_mid;
        digits = $urandom;
        dp_in  = N'($urandom);
        blank  = '0;
        for (int t = 0; t < N && exp_idx != 5; t++) run_tick(10, 10, 1'b0);
        for (int t = 0; t < N && exp_idx != 5; t++) run_tick(10, 10, 1'b0);
        n_cmp++;
        if (bus_l.an !== 8'hDF) begin
            n_err++;
            $display("FAIL mid_digit5 an=%h want=DF", bus_l.an);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (obs_l !== dark_pins(1'b1)) begin
            n_err++;
            $display("FAIL mid_reset_al1 got=%h want=%h", obs_l, dark_pins(1'b1));
        end
        n_cmp++;
        if (obs_h !== dark_pins(1'b0)) begin
            n_err++;
            $display("FAIL mid_reset_al0 got=%h want=%h", obs_h, dark_pins(1'b0));
        end
        repeat (3) @(posedge clk);
        release_reset();
        fs_seen = 0;
        run_tick(10, 10, 1'b0);
        n_cmp++;
        if (fs_seen != 1) begin
            n_err++;
            $display("FAIL mid_frame got=%0d want=1", fs_seen);
        end
        n_cmp++;
        if (bus_l.an !== 8'hFE || bus_h.an !== 8'h01) begin
            n_err++;
            $display("FAIL mid_digit0 an_al1=%h an_al0=%h want FE/01", bus_l.an, bus_h.an);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_scan_order();
        test_latency();
        test_blank_dp();
        test_hex_decode();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
